wb_write_buffer: RTL and testbench

WB_WRITE_BUFFER -- requirements
Module: wb_write_buffer

---
 rtl/cpu_pkg.sv | 10 +
 rtl/wb_write_buffer_if.sv | 41 ++++
 rtl/wb_bypass_match.sv | 30 +++
 rtl/wb_write_buffer.sv | 79 +++++++
 tb/tb_wb_write_buffer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths and the writeback buffer entry type.
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/wb_write_buffer_if.sv
// Writeback buffer bus: request handshake, register-file write port and bypass lookups.
interface wb_write_buffer_if
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Request handshake: a transfer happens on a rising edge where wr_valid && wr_ready.
  // wr_ready depends only on buffer occupancy, never on wr_valid or rf_grant.
  logic                  wr_valid;
  logic                  wr_ready;
  logic [REG_ADDR_W-1:0] wr_reg;
  logic [DATA_W-1:0]     wr_data;

  logic                  rf_grant;
  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0]     WriteData;

  logic [REG_ADDR_W-1:0] ReadRegister1;
  logic [REG_ADDR_W-1:0] ReadRegister2;
  logic                  hit1;
  logic                  hit2;
  logic [DATA_W-1:0]     BypassData1;
  logic [DATA_W-1:0]     BypassData2;

  logic [CNT_W-1:0]      count;

  modport slave (
    input  wr_valid, wr_reg, wr_data, rf_grant, ReadRegister1, ReadRegister2,
    output wr_ready, RegWrite, WriteRegister, WriteData,
    output hit1, hit2, BypassData1, BypassData2, count
  );

  modport master (
    output wr_valid, wr_reg, wr_data, rf_grant, ReadRegister1, ReadRegister2,
    input  wr_ready, RegWrite, WriteRegister, WriteData,
    input  hit1, hit2, BypassData1, BypassData2, count
  );
endinterface

// File: rtl/wb_bypass_match.sv
// Youngest-match search of the pending writeback entries for one read address.
module wb_bypass_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]      valid,
  input  logic [PTR_W-1:0]      head,
  input  logic [REG_ADDR_W-1:0] read_reg,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);
  logic [PTR_W-1:0] idx;

  // Walk from oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (read_reg != '0 && valid[idx] && entries[idx].reg_addr == read_reg) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end
endmodule

// File: rtl/wb_write_buffer.sv
// In-order writeback FIFO draining into the register file, with youngest-entry bypass.
module wb_write_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  wb_write_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t [DEPTH-1:0] mem;
  logic [DEPTH-1:0]      valid;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic                  not_empty;
  logic                  enq;
  logic                  deq;

  assign not_empty    = (count != '0);
  assign bus.wr_ready = (count != CNT_W'(DEPTH));
  // Writes to r0 complete the handshake but are dropped here.
  assign enq          = bus.wr_valid && bus.wr_ready && (bus.wr_reg != '0);
  assign deq          = not_empty && bus.rf_grant;

  assign bus.RegWrite      = deq;
  assign bus.WriteRegister = not_empty ? mem[head].reg_addr : '0;
  assign bus.WriteData     = not_empty ? mem[head].data : '0;
  assign bus.count         = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (enq) begin
        tail        <= tail + 1'b1;
        valid[tail] <= 1'b1;
      end
      if (deq) begin
        head        <= head + 1'b1;
        valid[head] <= 1'b0;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage is qualified by the valid bits, so it carries no reset.
  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= '{reg_addr: bus.wr_reg, data: bus.wr_data};
  end

  wb_bypass_match #(.DEPTH(DEPTH)) u_match1 (
    .entries  (mem),
    .valid    (valid),
    .head     (head),
    .read_reg (bus.ReadRegister1),
    .hit      (bus.hit1),
    .data     (bus.BypassData1)
  );

  wb_bypass_match #(.DEPTH(DEPTH)) u_match2 (
    .entries  (mem),
    .valid    (valid),
    .head     (head),
    .read_reg (bus.ReadRegister2),
    .hit      (bus.hit2),
    .data     (bus.BypassData2)
  );
endmodule

// File: tb/tb_wb_write_buffer.sv
// Bench for wb_write_buffer: directed scenarios plus random traffic against a queue model.
module tb_wb_write_buffer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [36:0] exp_q[$];

  wb_write_buffer_if #(.DEPTH(DEPTH)) bus ();

  wb_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  // Model: pending writes as {reg,data} in acceptance order, front = oldest.
  function automatic logic [32:0] m_lookup(input logic [4:0] ra);
    logic [32:0] r;
    r = '0;
    if (ra != 5'd0)
      foreach (exp_q[i]) if (exp_q[i][36:32] == ra) r = {1'b1, exp_q[i][31:0]};
    return r;
  endfunction

  task automatic advance();
    logic [36:0] item;
    bit do_enq;
    bit do_deq;
    do_deq = (exp_q.size() != 0) && bus.rf_grant && reset;
    do_enq = bus.wr_valid && (exp_q.size() != DEPTH) && (bus.wr_reg != 5'd0) && reset;
    item   = {bus.wr_reg, bus.wr_data};
    @(posedge clk);
    if (do_deq) void'(exp_q.pop_front());
    if (do_enq) exp_q.push_back(item);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.wr_valid = 1'b0;
    bus.wr_reg = '0;
    bus.wr_data = '0;
    bus.rf_grant = 1'b0;
    bus.ReadRegister1 = '0;
    bus.ReadRegister2 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.rf_grant = 1'b1;
    bus.ReadRegister1 = 5'd5;
    bus.ReadRegister2 = 5'd9;
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (bus.count !== 3'd0) begin n_errors++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_errors++; $display("FAIL rst_wr_ready got=%b exp=1", bus.wr_ready); end
    n_checks++; if (bus.RegWrite !== 1'b0) begin n_errors++; $display("FAIL rst_regwrite got=%b exp=0", bus.RegWrite); end
    n_checks++; if (bus.WriteRegister !== 5'd0 || bus.WriteData !== 32'd0) begin
      n_errors++; $display("FAIL rst_write_port got=%0h/%0h exp=0/0", bus.WriteRegister, bus.WriteData); end
    n_checks++; if ({bus.hit1, bus.hit2, bus.BypassData1, bus.BypassData2} !== '0) begin
      n_errors++; $display("FAIL rst_bypass got=%b%b %0h %0h exp=all 0", bus.hit1, bus.hit2, bus.BypassData1, bus.BypassData2); end
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bypass_order();
    bus.rf_grant = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_reg = 5'd5; bus.wr_data = 32'hA;
    advance();
    bus.wr_data = 32'hB;
    advance();
    bus.wr_valid = 1'b0;
    bus.ReadRegister1 = 5'd5;
    #1;
    n_checks++; if (bus.hit1 !== 1'b1 || bus.BypassData1 !== 32'hB) begin
      n_errors++; $display("FAIL youngest_bypass got=%b/%0h exp=1/b", bus.hit1, bus.BypassData1); end
    n_checks++; if (bus.count !== 3'd2 || bus.RegWrite !== 1'b0) begin
      n_errors++; $display("FAIL hold_no_grant got=%0d/%b exp=2/0", bus.count, bus.RegWrite); end
    bus.rf_grant = 1'b1;
    #1;
    n_checks++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd5 || bus.WriteData !== 32'hA) begin
      n_errors++; $display("FAIL first_write got=%b r%0d %0h exp=1 r5 a", bus.RegWrite, bus.WriteRegister, bus.WriteData); end
    advance();
    #1;
    n_checks++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd5 || bus.WriteData !== 32'hB) begin
      n_errors++; $display("FAIL second_write got=%b r%0d %0h exp=1 r5 b", bus.RegWrite, bus.WriteRegister, bus.WriteData); end
    advance();
    #1;
    n_checks++; if (bus.count !== 3'd0 || bus.RegWrite !== 1'b0 || bus.hit1 !== 1'b0) begin
      n_errors++; $display("FAIL drained got=%0d/%b/%b exp=0/0/0", bus.count, bus.RegWrite, bus.hit1); end
    idle_inputs();
  endtask

  task automatic test_full();
    bus.rf_grant = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      bus.wr_valid = 1'b1; bus.wr_reg = 5'(i); bus.wr_data = 32'(i * 16);
      advance();
    end
    bus.wr_reg = 5'd5; bus.wr_data = 32'h50;
    #1;
    n_checks++; if (bus.wr_ready !== 1'b0 || bus.count !== 3'd4) begin
      n_errors++; $display("FAIL full_state got=%b/%0d exp=0/4", bus.wr_ready, bus.count); end
    advance();
    #1;
    n_checks++; if (bus.count !== 3'd4) begin n_errors++; $display("FAIL full_held got=%0d exp=4", bus.count); end
    bus.rf_grant = 1'b1;
    #1;
    n_checks++; if (bus.RegWrite !== 1'b1 || bus.wr_ready !== 1'b0 || bus.WriteRegister !== 5'd1) begin
      n_errors++; $display("FAIL full_grant got=%b/%b r%0d exp=1/0 r1", bus.RegWrite, bus.wr_ready, bus.WriteRegister); end
    advance();
    bus.rf_grant = 1'b0;
    #1;
    n_checks++; if (bus.wr_ready !== 1'b1 || bus.count !== 3'd3) begin
      n_errors++; $display("FAIL after_grant got=%b/%0d exp=1/3", bus.wr_ready, bus.count); end
    advance();
    bus.wr_valid = 1'b0;
    bus.rf_grant = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      #1;
      n_checks++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'(i) || bus.WriteData !== 32'(i * 16)) begin
        n_errors++; $display("FAIL full_drain got=%b r%0d %0h exp=1 r%0d %0h", bus.RegWrite, bus.WriteRegister, bus.WriteData, i, i * 16); end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    bus.rf_grant = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_reg = 5'd0; bus.wr_data = 32'hFFFF;
    #1;
    n_checks++; if (bus.wr_ready !== 1'b1 || bus.RegWrite !== 1'b0) begin
      n_errors++; $display("FAIL r0_accept got=%b/%b exp=1/0", bus.wr_ready, bus.RegWrite); end
    advance();
    bus.wr_valid = 1'b0;
    #1;
    n_checks++; if (bus.count !== 3'd0 || bus.RegWrite !== 1'b0) begin
      n_errors++; $display("FAIL r0_dropped got=%0d/%b exp=0/0", bus.count, bus.RegWrite); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d[11];
    bus.rf_grant = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      d[i] = $urandom;
      bus.wr_valid = 1'b1; bus.wr_reg = 5'(i); bus.wr_data = d[i];
      #1;
      n_checks++; if (bus.count !== ((i == 1) ? 3'd0 : 3'd1) || bus.RegWrite !== (i != 1)) begin
        n_errors++; $display("FAIL stream_state i=%0d got=%0d/%b", i, bus.count, bus.RegWrite); end
      if (i > 1) begin
        n_checks++; if (bus.WriteRegister !== 5'(i - 1) || bus.WriteData !== d[i-1]) begin
          n_errors++; $display("FAIL stream_order got=r%0d %0h exp=r%0d %0h", bus.WriteRegister, bus.WriteData, i - 1, d[i-1]); end
      end
      advance();
    end
    bus.wr_valid = 1'b0;
    #1;
    n_checks++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd10 || bus.WriteData !== d[10]) begin
      n_errors++; $display("FAIL stream_last got=%b r%0d %0h exp=1 r10 %0h", bus.RegWrite, bus.WriteRegister, bus.WriteData, d[10]); end
    advance();
    #1;
    n_checks++; if (bus.count !== 3'd0) begin n_errors++; $display("FAIL stream_empty got=%0d exp=0", bus.count); end
    idle_inputs();
  endtask

  task automatic test_drain_bypass();
    bus.wr_valid = 1'b1; bus.wr_reg = 5'd3; bus.wr_data = 32'h7;
    advance();
    bus.wr_valid = 1'b0;
    bus.rf_grant = 1'b1;
    bus.ReadRegister2 = 5'd3;
    #1;
    n_checks++; if (bus.RegWrite !== 1'b1 || bus.hit2 !== 1'b1 || bus.BypassData2 !== 32'h7) begin
      n_errors++; $display("FAIL drain_bypass got=%b/%b/%0h exp=1/1/7", bus.RegWrite, bus.hit2, bus.BypassData2); end
    advance();
    #1;
    n_checks++; if (bus.hit2 !== 1'b0 || bus.BypassData2 !== 32'd0) begin
      n_errors++; $display("FAIL drain_bypass_after got=%b/%0h exp=0/0", bus.hit2, bus.BypassData2); end
    idle_inputs();
  endtask

  task automatic test_reset_midop();
    bus.wr_valid = 1'b1; bus.wr_reg = 5'd6; bus.wr_data = 32'h1;
    advance();
    bus.wr_reg = 5'd7; bus.wr_data = 32'h2;
    advance();
    bus.wr_valid = 1'b0;
    bus.ReadRegister1 = 5'd6;
    bus.ReadRegister2 = 5'd7;
    #1;
    n_checks++; if (bus.count !== 3'd2 || bus.hit1 !== 1'b1) begin
      n_errors++; $display("FAIL pre_reset got=%0d/%b exp=2/1", bus.count, bus.hit1); end
    #1 reset = 1'b0;
    exp_q.delete();
    bus.rf_grant = 1'b1;
    #1;
    n_checks++; if (bus.count !== 3'd0 || bus.RegWrite !== 1'b0 || bus.hit1 !== 1'b0 || bus.hit2 !== 1'b0) begin
      n_errors++; $display("FAIL async_reset got=%0d/%b/%b/%b exp=0/0/0/0", bus.count, bus.RegWrite, bus.hit1, bus.hit2); end
    advance();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (bus.count !== 3'd0 || bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd0) begin
        n_errors++; $display("FAIL post_reset got=%0d/%b/r%0d exp=0/0/r0", bus.count, bus.RegWrite, bus.WriteRegister); end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int gp;
    int exp_n;
    logic [36:0] hd;
    logic [32:0] l1;
    logic [32:0] l2;
    for (int c = 0; c < 400; c++) begin
      case (c / 100)
        0: gp = 20;
        1: gp = 85;
        2: gp = 50;
        default: gp = 95;
      endcase
      bus.wr_valid = ($urandom_range(0, 3) != 0);
      bus.wr_reg = 5'($urandom_range(0, 7));
      bus.wr_data = $urandom;
      bus.rf_grant = ($urandom_range(0, 99) < gp);
      bus.ReadRegister1 = 5'($urandom_range(0, 7));
      bus.ReadRegister2 = 5'($urandom_range(0, 7));
      exp_n = exp_q.size();
      hd = (exp_n != 0) ? exp_q[0] : '0;
      l1 = m_lookup(bus.ReadRegister1);
      l2 = m_lookup(bus.ReadRegister2);
      #1;
      n_checks++; if (bus.count !== CNT_W'(exp_n)) begin
        n_errors++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, bus.count, exp_n); end
      n_checks++; if (bus.wr_ready !== (exp_n != DEPTH)) begin
        n_errors++; $display("FAIL rnd_wr_ready c=%0d got=%b exp=%b", c, bus.wr_ready, exp_n != DEPTH); end
      n_checks++; if (bus.RegWrite !== ((exp_n != 0) && bus.rf_grant)) begin
        n_errors++; $display("FAIL rnd_regwrite c=%0d got=%b", c, bus.RegWrite); end
      n_checks++; if ({bus.WriteRegister, bus.WriteData} !== hd) begin
        n_errors++; $display("FAIL rnd_head c=%0d got=r%0d %0h exp=r%0d %0h", c, bus.WriteRegister, bus.WriteData, hd[36:32], hd[31:0]); end
      n_checks++; if ({bus.hit1, bus.BypassData1} !== l1) begin
        n_errors++; $display("FAIL rnd_bypass1 c=%0d got=%b/%0h exp=%b/%0h", c, bus.hit1, bus.BypassData1, l1[32], l1[31:0]); end
      n_checks++; if ({bus.hit2, bus.BypassData2} !== l2) begin
        n_errors++; $display("FAIL rnd_bypass2 c=%0d got=%b/%0h exp=%b/%0h", c, bus.hit2, bus.BypassData2, l2[32], l2[31:0]); end
      advance();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_bypass_order();
    test_full();
    test_zero_reg();
    test_back_to_back();
    test_drain_bypass();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
